fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WORDSIZE, default 64: width of PC and addresses.
REQ-002 Parameter INSTSIZE, default 32: instruction width.
REQ-003 Parameter DEPTH, default 4: prefetch queue entries; power of two, at least 2.
REQ-004 Parameter RESETPC, default 0: first fetch address after reset.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port stall, input, 1: consumer (IF-ID register) is not accepting this cycle.
REQ-008 Port branch, input, 1: redirect request from write-back branch resolution.
REQ-009 Port branchpc, input, WORDSIZE: redirect target.
REQ-010 Port imem_req, output, 1: instruction-memory read request.
REQ-011 Port imem_addr, output, WORDSIZE: read address; stable while imem_req is high and imem_ready is low.
REQ-012 Port imem_ready, input, 1: memory returns imem_data this cycle; the transfer completes on the edge where imem_req and imem_ready are both high.
REQ-013 Port imem_data, input, INSTSIZE: fetched instruction.
REQ-014 Port valid, output, 1: queue head holds an instruction.
REQ-015 Port pc, output, WORDSIZE: address of the head instruction.
REQ-016 Port instruction, output, INSTSIZE: head instruction.

Function
REQ-017 Block SHALL hold a FIFO of DEPTH {pc, instruction} entries, a fetch PC (fpc), an occupancy count, and an FSM with states IDLE, REQ and DISCARD.
REQ-018 Only one memory request SHALL be outstanding at a time; imem_req SHALL be high exactly in REQ and DISCARD.
REQ-019 In REQ, imem_addr SHALL equal fpc; in DISCARD, it SHALL hold the address of the abandoned request.
REQ-020 A completed transfer in REQ without branch SHALL push {fpc, imem_data} and set fpc to fpc+4, modulo 2^WORDSIZE.
REQ-021 After such a push, the FSM SHALL stay in REQ if the post-edge count is below DEPTH, else go to IDLE.
REQ-022 IDLE SHALL go to REQ on any edge where the post-edge count is below DEPTH.
REQ-023 valid SHALL be high iff count is non-zero; pc and instruction SHALL show the head entry when valid, otherwise all zeros.
REQ-024 Pop SHALL occur on an edge where valid is high and stall is low; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-025 Latency: with a zero-wait memory, an instruction pushed at edge N SHALL be visible on the outputs after edge N; throughput SHALL be one instruction per cycle.
REQ-026 branch SHALL have priority over push and pop: on that edge the queue empties and fpc loads branchpc with bits [1:0] forced to 0.
REQ-027 FSM on a branch edge:
- REQ with imem_ready high: response dropped; next state REQ.
- REQ with imem_ready low: next state DISCARD.
- IDLE: next state REQ.
- DISCARD: next state stays DISCARD.
REQ-028 DISCARD SHALL drop the response on completion and go to REQ at the new fpc.
REQ-029 branch and stall together SHALL behave as branch alone.
REQ-030 count SHALL never exceed DEPTH, and no push SHALL occur while count equals DEPTH.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-032 On rst high, asynchronously: fpc=RESETPC, count=0, pointers=0, FSM=IDLE, imem_req=0, valid=0, pc=0, instruction=0.
REQ-033 On the first edge after rst falls, the FSM SHALL enter REQ with imem_addr=RESETPC.
REQ-034 rst asserted mid-transfer SHALL abandon the request; a late imem_ready SHALL be ignored while in IDLE.

Verification
REQ-035 Zero-wait memory, stall=0, no branch:
- After reset: valid rises 2 edges after rst release.
- pc sequence 0x0, 0x4, 0x8, ..., one per cycle.
- Each instruction matches memory contents.
REQ-036 stall held high, zero-wait memory:
- count reaches 4, then FSM goes to IDLE and imem_req drops.
- Head stays pc=0x0.
- After stall is released: 0x0, 0x4, 0x8, 0xC in order, then fetching resumes at 0x10.
REQ-037 Memory with 3 wait cycles, branch to 0x100 on the second cycle of a request for 0x8:
- imem_addr holds 0x8 until ready.
- Data for 0x8 is never presented.
- Next imem_addr is 0x100.
REQ-038 branch to 0x203 with the queue full:
- valid=0 on the next cycle.
- Next fetch address is 0x200.
- First valid pc is 0x200.
REQ-039 branch coincident with imem_ready and a pop:
- Response dropped; queue empty.
- Next imem_addr equals branchpc.
REQ-040 rst pulsed mid-stream:
- Outputs zero immediately, without waiting for a clock edge.
- Fetch restarts at RESETPC.
- No stale entry appears.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small
// prefetch FIFO of {pc, instruction} pairs, with branch redirect and discard.
module fetch_unit #(
    parameter int unsigned          WORDSIZE = 64,
    parameter int unsigned          INSTSIZE = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [WORDSIZE-1:0]  RESETPC  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch,
    input  logic [WORDSIZE-1:0] branchpc,
    output logic                imem_req,
    output logic [WORDSIZE-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [INSTSIZE-1:0] imem_data,
    output logic                valid,
    output logic [WORDSIZE-1:0] pc,
    output logic [INSTSIZE-1:0] instruction
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_C   = (PW+1)'(1);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

    state_e              state_q;
    logic                imem_req_q;
    logic [WORDSIZE-1:0] imem_addr_q;
    logic [WORDSIZE-1:0] fpc_q, fpc_d;
    logic [PW:0]         count_q, count_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic                push, pop;

    logic [WORDSIZE-1:0] pc_mem   [DEPTH];
    logic [INSTSIZE-1:0] inst_mem [DEPTH];

    assign valid       = (count_q != '0);
    assign pc          = valid ? pc_mem[rd_ptr_q]   : '0;
    assign instruction = valid ? inst_mem[rd_ptr_q] : '0;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;

    // Branch wins over both queue operations; the full guard keeps count bounded.
    assign push = (state_q == REQ) && imem_ready && !branch && (count_q != DEPTH_C);
    assign pop  = valid && !stall && !branch;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fpc_d    = fpc_q;
        if (branch) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fpc_d    = {branchpc[WORDSIZE-1:2], 2'b00};
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                fpc_d    = fpc_q + WORDSIZE'(4);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop) count_d = count_q + ONE_C;
            if (pop && !push) count_d = count_q - ONE_C;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESETPC;
            fpc_q       <= RESETPC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            fpc_q    <= fpc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            unique case (state_q)
                IDLE: begin
                    if (count_d < DEPTH_C) begin
                        state_q     <= REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fpc_d;
                    end
                end
                REQ: begin
                    if (branch && !imem_ready) begin
                        // Request still in flight: keep the old address until it drains.
                        state_q <= DISCARD;
                    end else if (branch || (imem_ready && count_d < DEPTH_C)) begin
                        imem_addr_q <= fpc_d;
                    end else if (imem_ready) begin
                        state_q    <= IDLE;
                        imem_req_q <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (imem_ready) begin
                        state_q     <= REQ;
                        imem_addr_q <= fpc_d;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: queue storage is not reset; count and pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fpc_q;
            inst_mem[wr_ptr_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, wait-state discard,
// branch redirects and asynchronous reset, against a wait-state memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [63:0] branchpc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instruction;

    int n_checks = 0;
    int n_errors = 0;
    int wait_cycles = 0;
    int wcnt;

    fetch_unit #(.WORDSIZE(64), .INSTSIZE(32), .DEPTH(4), .RESETPC(64'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branchpc(branchpc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_data(imem_data), .valid(valid), .pc(pc), .instruction(instruction)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return 32'hA500_0000 | {8'h00, a[23:0]};
    endfunction

    // Memory answers after wait_cycles idle cycles of a held request.
    assign imem_ready = imem_req && (wcnt == wait_cycles);
    assign imem_data  = memf(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst)                         wcnt <= 0;
        else if (!imem_req || imem_ready) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        stall  = 1'b0;
        branch = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!valid && k < 50) begin
            step(1);
            k++;
        end
        check(tag, {63'd0, valid}, 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and zero-wait streaming
        #1;
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_req",   {63'd0, imem_req}, 64'd0);
        check("rst_pc",    pc, 64'd0);
        check("rst_instr", {32'd0, instruction}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("first_req",   {63'd0, imem_req}, 64'd1);
        check("first_addr",  imem_addr, 64'd0);
        check("first_valid", {63'd0, valid}, 64'd0);
        step(1);
        check("stream_valid", {63'd0, valid}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            check("stream_pc",    pc, 64'(4 * i));
            check("stream_instr", {32'd0, instruction}, {32'd0, memf(64'(4 * i))});
            step(1);
        end

        // Back-pressure: fill to DEPTH, then drain in order
        do_reset();
        stall = 1'b1;
        step(4);
        check("fill_req_before_full", {63'd0, imem_req}, 64'd1);
        step(1);
        check("full_req_drop", {63'd0, imem_req}, 64'd0);
        check("full_head_pc",  pc, 64'd0);
        step(2);
        check("full_idle_req", {63'd0, imem_req}, 64'd0);
        check("full_hold_pc",  pc, 64'd0);
        stall = 1'b0;
        step(1);
        check("drain_pc1",     pc, 64'h4);
        check("resume_req",    {63'd0, imem_req}, 64'd1);
        check("resume_addr",   imem_addr, 64'h10);
        step(1);
        check("drain_pc2", pc, 64'h8);
        step(1);
        check("drain_pc3", pc, 64'hC);
        step(1);
        check("drain_pc4", pc, 64'h10);
        check("drain_instr4", {32'd0, instruction}, {32'd0, memf(64'h10)});

        // Wait-state memory: branch during the request for 0x8
        wait_cycles = 3;
        do_reset();
        begin
            int k = 0;
            while (!(imem_req && imem_addr == 64'h8) && k < 60) begin
                step(1);
                k++;
            end
        end
        check("ws_reach_8", imem_addr, 64'h8);
        check("ws_first_not_ready", {63'd0, imem_ready}, 64'd0);
        step(1);
        branch   = 1'b1;
        branchpc = 64'h100;
        step(1);
        branch = 1'b0;
        check("disc_req",   {63'd0, imem_req}, 64'd1);
        check("disc_addr",  imem_addr, 64'h8);
        check("disc_valid", {63'd0, valid}, 64'd0);
        begin
            int k = 0;
            while (!imem_ready && k < 10) begin
                check("disc_hold_addr", imem_addr, 64'h8);
                step(1);
                k++;
            end
        end
        check("disc_ready_seen", {63'd0, imem_ready}, 64'd1);
        check("disc_ready_addr", imem_addr, 64'h8);
        step(1);
        check("disc_dropped", {63'd0, valid}, 64'd0);
        check("redir_addr",   imem_addr, 64'h100);
        check("redir_req",    {63'd0, imem_req}, 64'd1);
        wait_valid("redir_valid");
        check("redir_pc",    pc, 64'h100);
        check("redir_instr", {32'd0, instruction}, {32'd0, memf(64'h100)});

        // Branch to unaligned target while full and stalled
        wait_cycles = 0;
        do_reset();
        stall = 1'b1;
        step(5);
        check("bfull_head", pc, 64'h0);
        branch   = 1'b1;
        branchpc = 64'h203;
        step(1);
        branch = 1'b0;
        check("bfull_valid", {63'd0, valid}, 64'd0);
        check("bfull_req",   {63'd0, imem_req}, 64'd1);
        check("bfull_addr",  imem_addr, 64'h200);
        step(1);
        check("bfull_first_valid", {63'd0, valid}, 64'd1);
        check("bfull_first_pc",    pc, 64'h200);
        stall = 1'b0;

        // Branch coincident with a completing transfer and a pop
        do_reset();
        step(6);
        check("bco_valid_before", {63'd0, valid}, 64'd1);
        check("bco_ready_before", {63'd0, imem_ready}, 64'd1);
        branch   = 1'b1;
        branchpc = 64'h340;
        step(1);
        branch = 1'b0;
        check("bco_empty", {63'd0, valid}, 64'd0);
        check("bco_addr",  imem_addr, 64'h340);
        step(1);
        check("bco_pc",    pc, 64'h340);
        check("bco_instr", {32'd0, instruction}, {32'd0, memf(64'h340)});

        // Asynchronous reset in the middle of a transfer
        wait_cycles = 2;
        do_reset();
        stall = 1'b1;
        step(8);
        check("mid_valid",     {63'd0, valid}, 64'd1);
        check("mid_in_flight", {63'd0, imem_req & ~imem_ready}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, valid}, 64'd0);
        check("arst_pc",    pc, 64'd0);
        check("arst_instr", {32'd0, instruction}, 64'd0);
        check("arst_req",   {63'd0, imem_req}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        stall       = 1'b0;
        wait_cycles = 0;
        step(1);
        check("restart_addr",  imem_addr, 64'h0);
        check("restart_valid", {63'd0, valid}, 64'd0);
        step(1);
        check("restart_pc",    pc, 64'h0);
        check("restart_instr", {32'd0, instruction}, {32'd0, memf(64'h0)});
        step(1);
        check("restart_pc2",   pc, 64'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
